// File: rtl/pi_wheel_scheduler.sv
// Time-multiplexed incremental PI controller: one shared multiplier sweeps all wheel channels
// per tick, applying deadband and saturation, then publishes every duty together.
module pi_wheel_scheduler #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned SCALE_SHIFT = 7,
  parameter int          DEADBAND    = 32,
  parameter int unsigned OUT_SHIFT   = 8,
  parameter int          DUTY_MAX    = 4095,
  parameter int          DUTY_MIN    = -4095
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_i,
  input  logic [NCH-1:0]      en_i,
  input  logic [NCH*16-1:0]   set_bus_i,
  input  logic [NCH*32-1:0]   fb_bus_i,
  input  logic [31:0]         kp_ki_i,
  input  logic [31:0]         kp_i,
  output logic [NCH*16-1:0]   duty_bus_o,
  output logic                duty_valid_o,
  output logic                busy_o,
  output logic                overrun_o
);

  localparam int unsigned      ChW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [ChW-1:0]   LastCh = ChW'(NCH - 1);
  localparam logic signed [31:0] DbPos  = 32'(DEADBAND);
  localparam logic signed [31:0] DbNeg  = -DbPos;
  localparam logic signed [32:0] AccMax = 33'(DUTY_MAX);
  localparam logic signed [32:0] AccMin = 33'(DUTY_MIN);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMulP,
    StMulI,
    StAcc,
    StDone
  } state_e;

  state_e              state_q;
  logic [ChW-1:0]      ch_q;
  logic signed [31:0]  gain_a_q;
  logic signed [31:0]  gain_b_q;
  logic signed [31:0]  err_q;
  logic signed [31:0]  p_q;
  logic signed [31:0]  q_q;
  logic                en_c_q;
  logic signed [31:0]  pre_err_q [NCH];
  logic signed [32:0]  acc_q     [NCH];
  logic [NCH*16-1:0]   duty_q;
  logic                duty_valid_q;
  logic                busy_q;
  logic                overrun_q;

  logic signed [15:0]  set_arr [NCH];
  logic signed [31:0]  fb_arr  [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign set_arr[i] = set_bus_i[16*i +: 16];
    assign fb_arr[i]  = fb_bus_i[32*i +: 32];
  end

  logic signed [31:0] set_ext;
  logic signed [31:0] e_raw;
  logic signed [31:0] e_db;
  logic signed [31:0] mul_a;
  logic signed [31:0] mul_b;
  logic signed [31:0] mul_res;
  logic signed [31:0] delta;
  logic signed [31:0] delta_sh;
  logic signed [32:0] acc_sum;
  logic signed [32:0] acc_sat;

  always_comb begin
    set_ext  = 32'(set_arr[ch_q]);
    e_raw    = (set_ext <<< SCALE_SHIFT) - fb_arr[ch_q];
    e_db     = ((e_raw > DbNeg) && (e_raw < DbPos)) ? '0 : e_raw;
    // Single multiplier: gain A x current error in MULP, gain B x previous error otherwise.
    mul_a    = (state_q == StMulP) ? gain_a_q : gain_b_q;
    mul_b    = (state_q == StMulP) ? err_q : pre_err_q[ch_q];
    mul_res  = mul_a * mul_b;
    delta    = p_q - q_q;
    delta_sh = delta >>> OUT_SHIFT;
    acc_sum  = acc_q[ch_q] + 33'(delta_sh);
    if (acc_sum > AccMax) begin
      acc_sat = AccMax;
    end else if (acc_sum < AccMin) begin
      acc_sat = AccMin;
    end else begin
      acc_sat = acc_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ch_q         <= '0;
      gain_a_q     <= '0;
      gain_b_q     <= '0;
      err_q        <= '0;
      p_q          <= '0;
      q_q          <= '0;
      en_c_q       <= 1'b0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        pre_err_q[c] <= '0;
        acc_q[c]     <= '0;
      end
    end else begin
      duty_valid_q <= 1'b0;
      // Any tick outside IDLE (DONE included) is dropped and flagged.
      overrun_q    <= tick_i && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (tick_i) begin
            state_q <= StLoad;
            ch_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        StLoad: begin
          if (ch_q == '0) begin
            gain_a_q <= kp_ki_i;
            gain_b_q <= kp_i;
          end
          err_q   <= e_db;
          en_c_q  <= en_i[ch_q];
          state_q <= StMulP;
        end
        StMulP: begin
          p_q     <= mul_res;
          state_q <= StMulI;
        end
        StMulI: begin
          q_q     <= mul_res;
          state_q <= StAcc;
        end
        StAcc: begin
          if (en_c_q) begin
            acc_q[ch_q]     <= acc_sat;
            pre_err_q[ch_q] <= err_q;
          end else begin
            acc_q[ch_q]     <= '0;
            pre_err_q[ch_q] <= '0;
            err_q           <= '0;
          end
          if (ch_q == LastCh) begin
            state_q <= StDone;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= StLoad;
          end
        end
        StDone: begin
          for (int c = 0; c < NCH; c++) begin
            duty_q[16*c +: 16] <= acc_q[c][15:0];
          end
          duty_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign duty_bus_o   = duty_q;
  assign duty_valid_o = duty_valid_q;
  assign busy_o       = busy_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_pi_wheel_scheduler.sv
// Directed bench for pi_wheel_scheduler: step, saturation, deadband, disable, overrun/timing
// and mid-sweep reset, with hand-computed expected duties.
module tb_pi_wheel_scheduler;

  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tick = 1'b0;
  logic [NCH-1:0]    en;
  logic [NCH*16-1:0] set_bus;
  logic [NCH*32-1:0] fb_bus;
  logic [31:0]       kp_ki;
  logic [31:0]       kp;
  logic [NCH*16-1:0] duty_bus;
  logic              duty_valid;
  logic              busy;
  logic              overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int dv_at, dv_cnt, busy_cyc, ov_cnt, dv_seen;

  pi_wheel_scheduler #(.NCH(NCH)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_i       (tick),
    .en_i         (en),
    .set_bus_i    (set_bus),
    .fb_bus_i     (fb_bus),
    .kp_ki_i      (kp_ki),
    .kp_i         (kp),
    .duty_bus_o   (duty_bus),
    .duty_valid_o (duty_valid),
    .busy_o       (busy),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int duty(input int c);
    return int'($signed(duty_bus[c*16 +: 16]));
  endfunction

  task automatic set_ch(input int c, input int s, input int f);
    set_bus[c*16 +: 16] = 16'(s);
    fb_bus[c*32 +: 32]  = 32'(f);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; tick is sampled at edge k, j counts negedges after edge k+j.
  // x1/x2 raise an extra tick sampled at edge k+x.
  task automatic run_sweep(input int win, input int x1, input int x2, output int at,
                           output int dvc, output int bc, output int oc);
    at  = -1;
    dvc = 0;
    bc  = 0;
    oc  = 0;
    tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    for (int j = 0; j < win; j++) begin
      if (duty_valid) begin
        dvc++;
        if (at < 0) at = j;
      end
      bc += int'(busy);
      oc += int'(overrun);
      tick = ((j + 1) == x1) || ((j + 1) == x2);
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  task automatic sweep();
    int a, b, c, d;
    run_sweep(19, -1, -1, a, b, c, d);
  endtask

  initial begin
    int step_exp [4] = '{2550, 3300, 4050, 4095};
    en      = '1;
    set_bus = '0;
    fb_bus  = '0;
    kp_ki   = 32'd360;
    kp      = 32'd210;
    repeat (3) @(negedge clk);
    check_val("rst_duty0", duty(0), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_valid", int'(duty_valid), 0);
    check_val("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Step response, first sweep also carries an overrun tick at k+5.
    set_ch(0, 10, 0);
    run_sweep(24, 5, -1, dv_at, dv_cnt, busy_cyc, ov_cnt);
    check_val("t_valid_at", dv_at, 17);
    check_val("t_valid_cnt", dv_cnt, 1);
    check_val("t_busy_cyc", busy_cyc, 17);
    check_val("t_overrun_cnt", ov_cnt, 1);
    check_val("step1", duty(0), 1800);
    for (int i = 0; i < 4; i++) begin
      sweep();
      check_val($sformatf("step%0d", i + 2), duty(0), step_exp[i]);
    end
    check_val("step_ch1", duty(1), 0);
    check_val("step_ch3", duty(3), 0);

    // Drive negative until the lower clamp holds.
    set_ch(0, -10, 0);
    sweep();
    check_val("neg1", duty(0), 1245);
    repeat (8) sweep();
    check_val("neg_clamp", duty(0), -4095);
    sweep();
    check_val("neg_clamp_hold", duty(0), -4095);

    // Deadband on channel 2.
    do_reset();
    check_val("rst2_duty0", duty(0), 0);
    set_ch(0, 0, 0);
    set_ch(2, 1, 100);
    sweep();
    check_val("db_inside", duty(2), 0);
    set_ch(2, 1, 96);
    sweep();
    check_val("db_edge", duty(2), 45);
    sweep();
    check_val("db_edge2", duty(2), 63);

    // Disable channel 1 while channel 3 keeps running.
    do_reset();
    set_ch(2, 0, 0);
    set_ch(1, 10, 0);
    set_ch(3, 5, 0);
    sweep();
    sweep();
    check_val("dis_pre_ch1", duty(1), 2550);
    check_val("dis_pre_ch3", duty(3), 1275);
    en[1] = 1'b0;
    sweep();
    check_val("dis_ch1", duty(1), 0);
    check_val("dis_ch3", duty(3), 1650);
    en[1] = 1'b1;
    sweep();
    check_val("reen_ch1", duty(1), 1800);
    check_val("reen_ch3", duty(3), 2025);

    // Tick during DONE is dropped; tick one cycle later is accepted.
    do_reset();
    set_ch(1, 0, 0);
    set_ch(3, 0, 0);
    set_ch(0, 10, 0);
    run_sweep(40, 17, 18, dv_at, dv_cnt, busy_cyc, ov_cnt);
    check_val("sp_overrun_cnt", ov_cnt, 1);
    check_val("sp_valid_cnt", dv_cnt, 2);
    check_val("sp_busy_cyc", busy_cyc, 34);
    check_val("sp_duty0", duty(0), 2550);

    // Asynchronous reset while channel 2 is in flight.
    tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_duty0", duty(0), 0);
    check_val("mid_rst_busy", int'(busy), 0);
    check_val("mid_rst_valid", int'(duty_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dv_seen = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      dv_seen += int'(duty_valid);
    end
    check_val("mid_rst_no_valid", dv_seen, 0);
    sweep();
    check_val("post_rst_step1", duty(0), 1800);
    sweep();
    check_val("post_rst_step2", duty(0), 2550);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
